// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: widths, opcodes and FSM state encoding.
package alu_pkg;

    localparam int DATA_W    = 8;
    localparam int RF_ADDR_W = 2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OPER = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    // Opcodes 110 and 111 are reserved and reported as errors.
    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_LDI;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two async operand reads, one async debug read, one sync write, async clear.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = RF_ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    input  logic [AW-1:0] raddr_dbg,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    output logic [DW-1:0] rdata_dbg
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a   = mem[raddr_a];
    assign rdata_b   = mem[raddr_b];
    assign rdata_dbg = mem[raddr_dbg];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit ALU: reads operands at accept, drives the ALU from registers,
// then writes the result back and reports it with a one-cycle res_valid pulse.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [2:0]           instr_op,
    input  logic [RF_ADDR_W-1:0] instr_rd,
    input  logic [RF_ADDR_W-1:0] instr_rs1,
    input  logic [RF_ADDR_W-1:0] instr_rs2,
    input  logic [DATA_W-1:0]    instr_imm,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [2:0]           alu_op,
    input  logic [DATA_W-1:0]    alu_out,
    input  logic                 alu_zero,
    output logic                 res_valid,
    output logic [DATA_W-1:0]    res_data,
    output logic                 res_zero,
    output logic                 res_err,
    input  logic [RF_ADDR_W-1:0] dbg_sel,
    output logic [DATA_W-1:0]    dbg_data
);

    logic [1:0]           state;
    logic [RF_ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0]    imm_q;
    logic [DATA_W-1:0]    rs1_data;
    logic [DATA_W-1:0]    rs2_data;
    logic                 op_legal;
    logic                 is_ldi;
    logic                 rf_we;
    logic [DATA_W-1:0]    wb_data;
    logic                 wb_zero;

    // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
    // instr_ready is high only in IDLE, and valid seen while busy is neither accepted nor queued.
    assign instr_ready = (state == ST_IDLE);

    assign op_legal = op_is_legal(alu_op);
    assign is_ldi   = (alu_op == OP_LDI);
    assign wb_data  = is_ldi ? imm_q : alu_out;
    assign wb_zero  = is_ldi ? (imm_q == '0) : alu_zero;
    assign rf_we    = (state == ST_OPER) && op_legal;

    alu_regfile #(
        .DW (DATA_W),
        .AW (RF_ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we        (rf_we),
        .waddr     (rd_q),
        .wdata     (wb_data),
        .raddr_a   (instr_rs1),
        .raddr_b   (instr_rs2),
        .raddr_dbg (dbg_sel),
        .rdata_a   (rs1_data),
        .rdata_b   (rs2_data),
        .rdata_dbg (dbg_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_q      <= '0;
            imm_q     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    res_valid <= 1'b0;
                    if (instr_valid) begin
                        rd_q   <= instr_rd;
                        imm_q  <= instr_imm;
                        alu_a  <= rs1_data;
                        alu_b  <= rs2_data;
                        alu_op <= instr_op;
                        state  <= ST_OPER;
                    end
                end
                ST_OPER: begin
                    // Illegal ops report zero data with the zero flag set and skip the write.
                    res_data  <= op_legal ? wb_data : '0;
                    res_zero  <= op_legal ? wb_zero : 1'b1;
                    res_err   <= ~op_legal;
                    res_valid <= 1'b1;
                    state     <= ST_WB;
                end
                ST_WB: begin
                    res_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    res_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural ALU downstream and a register-file reference model.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 instr_valid = 1'b0;
    logic                 instr_ready;
    logic [2:0]           instr_op = '0;
    logic [RF_ADDR_W-1:0] instr_rd = '0;
    logic [RF_ADDR_W-1:0] instr_rs1 = '0;
    logic [RF_ADDR_W-1:0] instr_rs2 = '0;
    logic [DATA_W-1:0]    instr_imm = '0;
    logic [DATA_W-1:0]    alu_a;
    logic [DATA_W-1:0]    alu_b;
    logic [2:0]           alu_op;
    logic [DATA_W-1:0]    alu_out;
    logic                 alu_zero;
    logic                 res_valid;
    logic [DATA_W-1:0]    res_data;
    logic                 res_zero;
    logic                 res_err;
    logic [RF_ADDR_W-1:0] dbg_sel = '0;
    logic [DATA_W-1:0]    dbg_data;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard entry: {err, zero, data}
    logic [DATA_W+1:0] exp_q[$];
    logic [DATA_W-1:0] rf_model [4];

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .instr_imm   (instr_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_zero    (res_zero),
        .res_err     (res_err),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    // Downstream ALU
    always_comb begin
        case (alu_op)
            3'd0:    alu_out = alu_a + alu_b;
            3'd1:    alu_out = alu_a - alu_b;
            3'd2:    alu_out = alu_a & alu_b;
            3'd3:    alu_out = alu_a | alu_b;
            3'd4:    alu_out = ~alu_a;
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called right after a negedge, so the #1 probes finish well before the next posedge.
    task automatic check_rf(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = i[RF_ADDR_W-1:0];
            #1;
            check($sformatf("%s rf[%0d]", tag, i), {24'd0, dbg_data}, {24'd0, rf_model[i]});
        end
    endtask

    // Reference: computed from the instruction semantics on the modelled register file.
    task automatic model_exec(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                              input logic [7:0] imm);
        int a;
        int b;
        int r;
        a = rf_model[rs1];
        b = rf_model[rs2];
        case (op)
            3'd0:    r = (a + b) % 256;
            3'd1:    r = (a - b + 256) % 256;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = 255 - a;
            3'd5:    r = imm;
            default: r = 0;
        endcase
        if (op > 3'd5) begin
            exp_q.push_back({1'b1, 1'b1, 8'h00});
        end else begin
            rf_model[rd] = r[7:0];
            exp_q.push_back({1'b0, (r == 0), r[7:0]});
        end
    endtask

    // Driver: issue one instruction, keep valid high while busy, check the result in WB.
    task automatic issue(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                         input logic [7:0] imm);
        logic [DATA_W+1:0] exp;
        @(negedge clk);
        check("ready idle", {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_rd    = rd[1:0];
        instr_rs1   = rs1[1:0];
        instr_rs2   = rs2[1:0];
        instr_imm   = imm;
        model_exec(op, rd, rs1, rs2, imm);
        @(negedge clk);
        check("ready oper", {31'd0, instr_ready}, 32'd0);
        check("valid oper", {31'd0, res_valid}, 32'd0);
        instr_op  = 3'($urandom_range(0, 7));
        instr_rd  = 2'($urandom_range(0, 3));
        instr_imm = 8'($urandom_range(0, 255));
        @(negedge clk);
        check("ready wb", {31'd0, instr_ready}, 32'd0);
        check("res_valid", {31'd0, res_valid}, 32'd1);
        exp = exp_q.pop_front();
        check("res_data", {24'd0, res_data}, {24'd0, exp[7:0]});
        check("res_zero", {31'd0, res_zero}, {31'd0, exp[8]});
        check("res_err", {31'd0, res_err}, {31'd0, exp[9]});
        instr_valid = 1'b0;
        check_rf("wb");
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rf_model[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset ready", {31'd0, instr_ready}, 32'd1);
        check("reset valid", {31'd0, res_valid}, 32'd0);
        check("reset data", {24'd0, res_data}, 32'd0);
        check_rf("reset");

        issue(OP_LDI, 1, 0, 0, 8'h05);
        issue(OP_LDI, 2, 0, 0, 8'h03);
        issue(OP_ADD, 3, 1, 2, 8'h00);
        issue(OP_SUB, 0, 2, 2, 8'h00);
        issue(OP_SUB, 0, 2, 1, 8'h00);
        issue(OP_LDI, 1, 0, 0, 8'hFF);
        issue(OP_LDI, 2, 0, 0, 8'h01);
        issue(OP_ADD, 0, 1, 2, 8'h00);
        issue(OP_NOT, 3, 1, 2, 8'h00);
        issue(OP_LDI, 1, 0, 0, 8'hF0);
        issue(OP_LDI, 2, 0, 0, 8'h3C);
        issue(OP_AND, 3, 1, 2, 8'h00);
        issue(OP_OR,  0, 1, 2, 8'h00);
        issue(3'b110, 1, 2, 3, 8'h55);
        issue(3'b111, 2, 0, 1, 8'hAA);
        issue(OP_LDI, 3, 0, 0, 8'h00);

        for (int n = 0; n < 40; n++) begin
            issue(3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 8'($urandom_range(0, 255)));
        end

        // Reset during OPER of an ADD: nothing written, no result pulse.
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = OP_ADD;
        instr_rd    = 2'd0;
        instr_rs1   = 2'd1;
        instr_rs2   = 2'd2;
        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) rf_model[i] = '0;
        exp_q.delete();
        #1;
        check("rst valid", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_rf("mid rst");
        @(negedge clk);
        check("post rst ready", {31'd0, instr_ready}, 32'd1);
        check("post rst valid", {31'd0, res_valid}, 32'd0);
        issue(OP_LDI, 2, 0, 0, 8'h42);
        issue(OP_ADD, 1, 2, 2, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
